// File: rtl/seg_display_pkg.sv
// Shared definitions for the three-digit seven-segment scanner:
// active-low segment patterns, the blank pattern, the digit count,
// the scan phase type and the one-hot-low anode helper.
package seg_display_pkg;

  localparam int SEG_DIGITS = 3;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG_HEX_0 = 8'hC0;
  localparam logic [7:0] SEG_HEX_1 = 8'hF9;
  localparam logic [7:0] SEG_HEX_2 = 8'hA4;
  localparam logic [7:0] SEG_HEX_3 = 8'hB0;
  localparam logic [7:0] SEG_HEX_4 = 8'h99;
  localparam logic [7:0] SEG_HEX_5 = 8'h92;
  localparam logic [7:0] SEG_HEX_6 = 8'h82;
  localparam logic [7:0] SEG_HEX_7 = 8'hF8;
  localparam logic [7:0] SEG_HEX_8 = 8'h80;
  localparam logic [7:0] SEG_HEX_9 = 8'h90;
  localparam logic [7:0] SEG_HEX_A = 8'h88;
  localparam logic [7:0] SEG_HEX_B = 8'h83;
  localparam logic [7:0] SEG_HEX_C = 8'hC6;
  localparam logic [7:0] SEG_HEX_D = 8'hA1;
  localparam logic [7:0] SEG_HEX_E = 8'h86;
  localparam logic [7:0] SEG_HEX_F = 8'h8E;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

  // Active-low enable for one digit; an out-of-range index lights nothing.
  function automatic logic [2:0] anode_onehot_low(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b110;
      2'd1:    return 3'b101;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex-to-seven-segment decoder, active-low, dp off.
module seg_hex_decode
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] pattern
);

  // Table lookup of the active-low pattern for one hex nibble.
  always_comb begin
    pattern = SEG_BLANK;
    case (nibble)
      4'h0: pattern = SEG_HEX_0;
      4'h1: pattern = SEG_HEX_1;
      4'h2: pattern = SEG_HEX_2;
      4'h3: pattern = SEG_HEX_3;
      4'h4: pattern = SEG_HEX_4;
      4'h5: pattern = SEG_HEX_5;
      4'h6: pattern = SEG_HEX_6;
      4'h7: pattern = SEG_HEX_7;
      4'h8: pattern = SEG_HEX_8;
      4'h9: pattern = SEG_HEX_9;
      4'hA: pattern = SEG_HEX_A;
      4'hB: pattern = SEG_HEX_B;
      4'hC: pattern = SEG_HEX_C;
      4'hD: pattern = SEG_HEX_D;
      4'hE: pattern = SEG_HEX_E;
      4'hF: pattern = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/seg_display.sv
// Three-digit multiplexed seven-segment scanner. Each digit owns a slot of
// 2^SCAN_BITS cycles that opens with a BLANK interval (anodes off) to avoid
// ghosting, then a DRIVE interval lighting the digit latched during BLANK.
// Optional feature macro: SEG_BLINK_EN adds the blink input and a free-running
// BLINK_BITS counter that gates the anodes off during its upper half.
module seg_display
  import seg_display_pkg::*;
#(
  parameter int SCAN_BITS    = 16,
  parameter int BLANK_CYCLES = 64
`ifdef SEG_BLINK_EN
  ,
  parameter int BLINK_BITS   = 24
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] seg_digits,
`ifdef SEG_BLINK_EN
  input  logic        blink,
`endif
  output logic [7:0]  seg,
  output logic [2:0]  anode
);

  localparam logic [SCAN_BITS-1:0] BLANK_END = SCAN_BITS'(BLANK_CYCLES);
  localparam logic [1:0]           LAST_IDX  = 2'(SEG_DIGITS - 1);

  logic [SCAN_BITS-1:0] cnt;
  logic [1:0]           idx;
  logic [3:0]           nibble;
  logic [3:0]           nibble_d;
  logic [3:0]           digit_sel;
  phase_e               phase;
  logic [2:0]           anode_d;
  logic [7:0]           pattern;
  logic [7:0]           seg_d;

  // Slot counter and digit index: idx steps once per counter wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt == '1) begin
        idx <= (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;
      end
    end
  end

`ifdef SEG_BLINK_EN
  logic [BLINK_BITS-1:0] blink_cnt;

  // Free-running blink timebase, independent of the scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
`endif

  // Phase, digit selection, nibble latch input and anode pattern.
  always_comb begin
    phase     = (cnt < BLANK_END) ? PH_BLANK : PH_DRIVE;
    digit_sel = 4'h0;
    case (idx)
      2'd0:    digit_sel = seg_digits[3:0];
      2'd1:    digit_sel = seg_digits[7:4];
      2'd2:    digit_sel = seg_digits[11:8];
      default: digit_sel = 4'h0;
    endcase
    // The latch follows the input only while dark, so the lit digit is frozen.
    nibble_d = (phase == PH_BLANK) ? digit_sel : nibble;
    anode_d  = (phase == PH_BLANK) ? 3'b111 : anode_onehot_low(idx);
`ifdef SEG_BLINK_EN
    if (blink && blink_cnt[BLINK_BITS-1]) begin
      anode_d = 3'b111;
    end
`endif
    // dp is never lit.
    seg_d = {1'b1, pattern[6:0]};
  end

  // Decode the value the nibble latch is about to hold, so seg and anode
  // leave the single register stage in step with each other.
  seg_hex_decode u_decode (
    .nibble  (nibble_d),
    .pattern (pattern)
  );

  // Output register stage; reset blanks the display immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nibble <= 4'h0;
      seg    <= SEG_BLANK;
      anode  <= 3'b111;
    end else begin
      nibble <= nibble_d;
      seg    <= seg_d;
      anode  <= anode_d;
    end
  end

endmodule
